// File: rtl/mvau_inp_reuse_buffer_pkg.sv
// mvau_defn: shared types and helpers for the MVAU input reuse buffer.
package mvau_defn;

    typedef enum logic {FILL, REPLAY} inp_buf_state_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_inp_mem.sv
// mvau_inp_mem: vector storage with synchronous write and combinational read.
// Depth is the full address space so any AW-bit address indexes a real entry.
module mvau_inp_mem #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mvau_inp_reuse_buffer.sv
// mvau_inp_reuse_buffer: forwards one input vector while storing it, then
// replays it NF-1 times so every neuron fold reuses the same activations.
module mvau_inp_reuse_buffer
    import mvau_defn::*;
#(
    parameter int TI      = 8,
    parameter int MatrixW = 8,
    parameter int MatrixH = 6,
    parameter int SIMD    = 2,
    parameter int PE      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    output logic          in_rdy,
    input  logic [TI-1:0] in,
    output logic          out_v,
    input  logic          out_rdy,
    output logic [TI-1:0] out,
    output logic          out_sf_last,
    output logic          out_nf_last,
    output logic          busy
);

    localparam int SF       = MatrixW / SIMD;
    localparam int NF       = MatrixH / PE;
    localparam int BUF_ADDR = addr_w(SF);
    localparam int NF_W     = addr_w(NF);
    localparam logic [BUF_ADDR-1:0] SF_LAST = BUF_ADDR'(SF - 1);
    localparam logic [NF_W-1:0]     NF_LAST = NF_W'(NF - 1);

    inp_buf_state_t      state_q, state_d;
    logic [BUF_ADDR-1:0] sf_q, sf_d;
    logic [NF_W-1:0]     nf_q, nf_d;
    logic [TI-1:0]       out_q, out_d, rdata;
    logic                out_v_q, out_v_d, sfl_q, sfl_d, nfl_q, nfl_d;
    logic                fill, adv, load, sf_end;

    assign fill   = state_q == FILL;
    assign adv    = !out_v_q || out_rdy;
    assign load   = fill ? in_v && adv : adv;
    assign sf_end = sf_q == SF_LAST;

    assign in_rdy      = fill && adv;
    assign busy        = !fill;
    assign out         = out_q;
    assign out_v       = out_v_q;
    assign out_sf_last = sfl_q;
    assign out_nf_last = nfl_q;

    mvau_inp_mem #(.W(TI), .AW(BUF_ADDR)) u_mem (
        .clk   (clk),
        .we    (fill && load),
        .waddr (sf_q),
        .wdata (in),
        .raddr (sf_q),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        sf_d    = sf_q;
        nf_d    = nf_q;
        out_d   = out_q;
        out_v_d = out_v_q && !out_rdy;
        sfl_d   = sfl_q;
        nfl_d   = nfl_q;
        if (load) begin
            out_d   = fill ? in : rdata;
            out_v_d = 1'b1;
            sfl_d   = sf_end;
            nfl_d   = fill ? NF == 1 : nf_q == NF_LAST;
            sf_d    = sf_end ? '0 : sf_q + 1'b1;
            if (sf_end && fill && NF > 1) begin
                state_d = REPLAY;
                nf_d    = NF_W'(1);
            end else if (sf_end && !fill) begin
                nf_d    = (nf_q == NF_LAST) ? '0 : nf_q + 1'b1;
                state_d = (nf_q == NF_LAST) ? FILL : REPLAY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            sf_q    <= '0;
            nf_q    <= '0;
            out_q   <= '0;
            out_v_q <= 1'b0;
            sfl_q   <= 1'b0;
            nfl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sf_q    <= sf_d;
            nf_q    <= nf_d;
            out_q   <= out_d;
            out_v_q <= out_v_d;
            sfl_q   <= sfl_d;
            nfl_q   <= nfl_d;
        end
    end

endmodule

// File: tb/tb_mvau_inp_reuse_buffer.sv
// tb_mvau_inp_reuse_buffer: three buffer configurations (SF4/NF3, SF4/NF1,
// SF1/NF3) against a transaction-level reference of expected output words.
module tb_mvau_inp_reuse_buffer;

    localparam int TI = 8;
    localparam int N  = 3;
    localparam int SFA [N] = '{4, 4, 1};
    localparam int NFA [N] = '{3, 1, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_v [N], in_rdy [N], out_v [N], out_rdy [N], sfl [N], nfl [N], busy [N];
    logic [TI-1:0] din [N], dout [N];

    logic [TI+1:0] exq [N][$];
    logic [TI-1:0] vec [N][$];
    bit            acc_q [N];
    bit            chk_en = 1'b0;
    int            errs = 0, checks = 0;

    always #5 clk = ~clk;

    mvau_inp_reuse_buffer #(.TI(TI), .MatrixW(8), .MatrixH(6), .SIMD(2), .PE(2)) u0 (
        .clk(clk), .rst(rst), .in_v(in_v[0]), .in_rdy(in_rdy[0]), .in(din[0]),
        .out_v(out_v[0]), .out_rdy(out_rdy[0]), .out(dout[0]),
        .out_sf_last(sfl[0]), .out_nf_last(nfl[0]), .busy(busy[0]));
    mvau_inp_reuse_buffer #(.TI(TI), .MatrixW(8), .MatrixH(2), .SIMD(2), .PE(2)) u1 (
        .clk(clk), .rst(rst), .in_v(in_v[1]), .in_rdy(in_rdy[1]), .in(din[1]),
        .out_v(out_v[1]), .out_rdy(out_rdy[1]), .out(dout[1]),
        .out_sf_last(sfl[1]), .out_nf_last(nfl[1]), .busy(busy[1]));
    mvau_inp_reuse_buffer #(.TI(TI), .MatrixW(2), .MatrixH(6), .SIMD(2), .PE(2)) u2 (
        .clk(clk), .rst(rst), .in_v(in_v[2]), .in_rdy(in_rdy[2]), .in(din[2]),
        .out_v(out_v[2]), .out_rdy(out_rdy[2]), .out(dout[2]),
        .out_sf_last(sfl[2]), .out_nf_last(nfl[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Input is taken only when no output words are pending beyond the one
    // being consumed right now.
    function automatic bit exp_rdy(input int i);
        return exq[i].size() == 0 || (exq[i].size() == 1 && out_rdy[i]);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                bit acc;
                acc = in_v[i] && exp_rdy(i);
                if (exq[i].size() > 0 && out_rdy[i]) void'(exq[i].pop_front());
                if (acc) begin
                    vec[i].push_back(din[i]);
                    exq[i].push_back({vec[i].size() == SFA[i], NFA[i] == 1, din[i]});
                    if (vec[i].size() == SFA[i]) begin
                        for (int p = 1; p < NFA[i]; p++)
                            for (int s = 0; s < SFA[i]; s++)
                                exq[i].push_back({s == SFA[i] - 1, p == NFA[i] - 1, vec[i][s]});
                        vec[i].delete();
                    end
                end
                acc_q[i] = acc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("i%0d out_v", i), 32'(out_v[i]), 32'(exq[i].size() > 0));
                check($sformatf("i%0d in_rdy", i), 32'(in_rdy[i]), 32'(exp_rdy(i)));
                check($sformatf("i%0d busy", i), 32'(busy[i]), 32'(exq[i].size() > 1));
                if (exq[i].size() > 0)
                    check($sformatf("i%0d word", i), 32'({sfl[i], nfl[i], dout[i]}), 32'(exq[i][0]));
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("i%0d rst out_v", i), 32'(out_v[i]), 32'd0);
            check($sformatf("i%0d rst in_rdy", i), 32'(in_rdy[i]), 32'd1);
            check($sformatf("i%0d rst busy", i), 32'(busy[i]), 32'd0);
            check($sformatf("i%0d rst out", i), 32'(dout[i]), 32'd0);
            check($sformatf("i%0d rst flags", i), 32'({sfl[i], nfl[i]}), 32'd0);
            exq[i].delete();
            vec[i].delete();
        end
        #1 rst = 1'b0;
    endtask

    task automatic run(input int cycles, input int pv, input int pr, input bit toggle);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_q[i]) din[i] = TI'($urandom);
                in_v[i]    = $urandom_range(0, 99) < pv;
                out_rdy[i] = toggle ? c[0] : $urandom_range(0, 99) < pr;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            in_v[i]    = 1'b0;
            out_rdy[i] = 1'b1;
            din[i]     = TI'($urandom);
            acc_q[i]   = 1'b0;
        end
        pulse_reset();
        chk_en = 1'b1;
        run(40, 100, 100, 1'b0);
        run(200, 70, 50, 1'b0);
        run(40, 100, 0, 1'b1);
        run(5, 100, 100, 1'b0);
        pulse_reset();
        run(40, 100, 100, 1'b0);
        run(200, 60, 80, 1'b0);
        run(60, 0, 100, 1'b0);
        for (int i = 0; i < N; i++)
            check($sformatf("i%0d drained", i), 32'(exq[i].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
